// File: rtl/omem_readback_streamer_pkg.sv
// Shared constants and FSM encoding for the O-Memory readback streamer.
package omem_readback_streamer_pkg;

  localparam int unsigned WbWidth     = 32;
  localparam int unsigned MaxCores    = 4;
  localparam int unsigned MaxCoreBits = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StDrain  = 2'd2,
    StFinish = 2'd3
  } omrb_state_e;

endpackage

// File: rtl/omem_rb_fifo.sv
// First-word fall-through FIFO with occupancy count; simultaneous push/pop legal when full.
module omem_rb_fifo #(
  parameter int unsigned Width = 34,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Upstream credit accounting must make this unreachable.
  push_on_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full && !pop_i));

endmodule

// File: rtl/omem_readback_streamer.sv
// Scans every core's O-Memory bank after a render and streams the words out with
// credit-based flow control so a stalled sink never causes a dropped word.
module omem_readback_streamer
  import omem_readback_streamer_pkg::*;
#(
  parameter int unsigned WB_WIDTH   = WbWidth,
  parameter int unsigned CORE_BITS  = MaxCoreBits,
  parameter int unsigned NUM_BANKS  = MaxCores,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  input  logic [WB_WIDTH-1:0]  iWordsPerBank,
  output logic [CORE_BITS-1:0] oOMEMBankSelect,
  output logic [WB_WIDTH-1:0]  oOMEMReadAddress,
  input  logic [WB_WIDTH-1:0]  iOMEMData,
  output logic [WB_WIDTH-1:0]  oData,
  output logic [CORE_BITS-1:0] oBank,
  output logic                 oValid,
  input  logic                 iReady,
  output logic                 oBusy,
  output logic                 oDone
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SumW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam logic [CORE_BITS-1:0] LastBank = CORE_BITS'(NUM_BANKS - 1);

  omrb_state_e           state_q;
  logic [WB_WIDTH-1:0]   wpb_q, addr_q;
  logic [CORE_BITS-1:0]  bank_q;
  logic                  busy_q, done_q;
  logic [RD_LAT-1:0]     pipe_vld_q;
  logic [CORE_BITS-1:0]  pipe_bank_q [RD_LAT];

  logic [CntW-1:0]       fifo_count;
  logic                  fifo_empty, fifo_pop, can_issue, drain_done;
  logic [SumW-1:0]       inflight, used;

  assign fifo_pop = !fifo_empty && iReady;

  // Credits already spent: buffered words plus reads still in the memory pipe,
  // less the word leaving this cycle.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + SumW'(pipe_vld_q[i]);
    used = SumW'(fifo_count) + inflight - SumW'(fifo_pop);
  end

  assign can_issue  = (state_q == StIssue) && (used < SumW'(FIFO_DEPTH));
  assign drain_done = (pipe_vld_q == '0) && (fifo_count == CntW'(fifo_pop));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      wpb_q   <= '0;
      addr_q  <= '0;
      bank_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (iStart) begin
            wpb_q  <= iWordsPerBank;
            addr_q <= '0;
            bank_q <= '0;
            busy_q <= 1'b1;
            if (iWordsPerBank == '0) begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end else begin
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          if (can_issue) begin
            if (addr_q == wpb_q - WB_WIDTH'(1)) begin
              addr_q <= '0;
              if (bank_q == LastBank) begin
                bank_q  <= '0;
                state_q <= StDrain;
              end else begin
                bank_q <= bank_q + CORE_BITS'(1);
              end
            end else begin
              addr_q <= addr_q + WB_WIDTH'(1);
            end
          end
        end
        StDrain: begin
          if (drain_done) begin
            state_q <= StFinish;
            done_q  <= 1'b1;
          end
        end
        StFinish: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_bank_q[i] <= '0;
    end else begin
      pipe_vld_q[0]  <= can_issue;
      pipe_bank_q[0] <= bank_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_bank_q[i] <= pipe_bank_q[i-1];
      end
    end
  end

  omem_rb_fifo #(
    .Width(WB_WIDTH + CORE_BITS),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .push_i (pipe_vld_q[RD_LAT-1]),
    .wdata_i({pipe_bank_q[RD_LAT-1], iOMEMData}),
    .pop_i  (fifo_pop),
    .rdata_o({oBank, oData}),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign oValid           = !fifo_empty;
  assign oBusy            = busy_q;
  assign oDone            = done_q;
  assign oOMEMBankSelect  = bank_q;
  assign oOMEMReadAddress = addr_q;

endmodule
